// File: rtl/slow_hold_timer.sv
// slow_hold_timer: asserts Slow for enabled peripheral accesses and holds it SlowTimeout*TICK_DIV clocks afterwards.
module slow_hold_timer #(
  parameter int TICK_DIV = 1024
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       Slow,
  output logic       SlowGate,
  output logic       SlowBusy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] lastTick = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} stateT;
  stateT state, stateNext;
  logic bactR, gateL, gateLNext, hit, load, tick;
  logic [PW-1:0] prescaler, prescalerNext;
  logic [3:0] count, countNext, tLoad, tLoadNext;
  assign hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
               (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);
  assign load = BACT && !bactR && hit;
  assign tick = prescaler == lastTick;
  assign tLoadNext = load ? SlowTimeout : tLoad;
  assign gateLNext = load ? SlowClockGate : gateL;
  always_comb begin
    stateNext = state;
    countNext = count;
    prescalerNext = '0;
    case (state)
      IDLE: stateNext = load ? ACCESS : IDLE;
      ACCESS: if (!BACT) begin
        stateNext = (tLoad == 4'd0) ? IDLE : HOLD;
        countNext = tLoad;
      end
      HOLD: if (load) stateNext = ACCESS;
      else begin
        // a retrigger above discards any coincident tick
        prescalerNext = tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          countNext = count - 4'd1;
          stateNext = (count <= 4'd1) ? IDLE : HOLD;
        end
      end
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state     <= IDLE;
      bactR     <= 1'b0;
      prescaler <= '0;
      count     <= '0;
      tLoad     <= '0;
      gateL     <= 1'b0;
      Slow      <= 1'b0;
      SlowGate  <= 1'b0;
      SlowBusy  <= 1'b0;
    end else begin
      state     <= stateNext;
      bactR     <= BACT;
      prescaler <= prescalerNext;
      count     <= countNext;
      tLoad     <= tLoadNext;
      gateL     <= gateLNext;
      Slow      <= stateNext != IDLE;
      SlowGate  <= (stateNext != IDLE) && gateLNext;
      SlowBusy  <= stateNext == HOLD;
    end
  end
endmodule

// File: tb/tb_slow_hold_timer.sv
// tb_slow_hold_timer: drives bus cycles and compares Slow/SlowGate/SlowBusy against a timestamp-based reference model.
module tb_slow_hold_timer;
  localparam int D = 4;
  localparam logic [5:0] NONE = 6'b000000, SND = 6'b000001, SCC = 6'b000100,
                         IWM = 6'b001000, VIA = 6'b010000, ALL = 6'b111111;
  typedef struct packed {logic b; logic [5:0] s; logic [5:0] e; logic [3:0] t; logic g;} vecT;
  logic CLK = 1'b0, nPOR = 1'b0, bact = 1'b0, cg = 1'b0;
  logic [5:0] sel = '0, en = '0;
  logic [3:0] tmo = '0;
  logic Slow, SlowGate, SlowBusy;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic mAccess = 1'b0, mGate = 1'b0, mPrev = 1'b0;
  logic [3:0] mT = '0;
  int mHoldEnd = 0;
  vecT q[$];

  slow_hold_timer #(.TICK_DIV(D)) dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(bact),
    .IACKCS(sel[5]), .VIACS(sel[4]), .IWMCS(sel[3]), .SCCCS(sel[2]), .SCSICS(sel[1]), .SndCS(sel[0]),
    .SlowIACK(en[5]), .SlowVIA(en[4]), .SlowIWM(en[3]), .SlowSCC(en[2]), .SlowSCSI(en[1]), .SlowSnd(en[0]),
    .SlowClockGate(cg), .SlowTimeout(tmo),
    .Slow(Slow), .SlowGate(SlowGate), .SlowBusy(SlowBusy)
  );

  always #5 CLK = ~CLK;

  // Model: Slow is high during an access and until a precomputed end cycle after it.
  function automatic logic [2:0] expOut();
    logic s, h;
    h = cyc < mHoldEnd;
    s = mAccess || h;
    return {s, s && mGate, !mAccess && h};
  endfunction

  task automatic step();
    @(posedge CLK);
    cyc++;
    if (!nPOR) begin
      mAccess = 1'b0; mHoldEnd = 0; mPrev = 1'b0;
    end else begin
      if (bact && !mPrev && |(sel & en)) begin
        mAccess = 1'b1; mT = tmo; mGate = cg;
      end else if (mAccess && !bact) begin
        mAccess = 1'b0; mHoldEnd = cyc + int'(mT) * D;
      end
      mPrev = bact;
    end
    #1;
  endtask

  task automatic push(input logic b, input logic [5:0] s, input logic [5:0] e,
                      input logic [3:0] t, input logic g, input int n);
    repeat (n) q.push_back({b, s, e, t, g});
  endtask

  task automatic apply(input vecT v);
    {bact, sel, en, tmo, cg} = v;
  endtask

  task automatic test_reset();
    push(0, NONE, NONE, 0, 0, 2);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset cycle %0d: outputs=%b expected 000", cyc, {Slow, SlowGate, SlowBusy});
      end
    end
    q.delete();
    nPOR = 1'b1;
    push(0, NONE, VIA, 3, 1, 1);
    push(1, VIA, VIA, 3, 1, 3);
    push(0, NONE, VIA, 3, 1, 5);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL reset_prep cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
    #1 nPOR = 1'b0;
    #1 vectors++;
    mAccess = 1'b0; mHoldEnd = 0; mPrev = 1'b0;
    if ({Slow, SlowGate, SlowBusy} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: outputs=%b expected 000 without a clock", {Slow, SlowGate, SlowBusy});
    end
    #1 nPOR = 1'b1;
    push(0, VIA, VIA, 3, 1, 10);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== 3'b000) begin
        miscompares++;
        $display("FAIL post_reset cycle %0d: outputs=%b expected 000", cyc, {Slow, SlowGate, SlowBusy});
      end
    end
    q.delete();
  endtask

  task automatic test_via_hold();
    int slowCnt = 0, busyCnt = 0;
    push(0, NONE, VIA, 2, 1, 2);
    push(1, VIA, VIA, 2, 1, 5);
    push(0, NONE, VIA, 2, 1, 12);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if (i >= 7) begin
        slowCnt += int'(Slow);
        busyCnt += int'(SlowBusy);
      end
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL via cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
    vectors++;
    if (1 + slowCnt !== 1 + 2 * D || busyCnt !== 2 * D) begin
      miscompares++;
      $display("FAIL via_length: slow cycles after fall=%0d busy=%0d expected %0d and %0d", 1 + slowCnt, busyCnt, 1 + 2 * D, 2 * D);
    end
  endtask

  task automatic test_scc();
    push(1, SCC, 6'b111011, 2, 1, 4);
    push(0, NONE, 6'b111011, 2, 1, 12);
    push(1, SCC, ALL, 0, 1, 4);
    push(0, NONE, ALL, 0, 1, 4);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL scc cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
  endtask

  task automatic test_retrigger();
    push(1, VIA, VIA | IWM, 2, 0, 3);
    push(0, NONE, VIA | IWM, 2, 0, 2 * D);
    push(1, IWM, VIA | IWM, 4, 1, 3);
    push(0, NONE, VIA | IWM, 4, 1, 4 * D + 4);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL retrigger cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
  endtask

  task automatic test_settings();
    push(1, VIA, VIA, 5, 1, 3);
    push(0, NONE, VIA, 5, 1, 6);
    push(0, NONE, VIA, 1, 0, 5 * D + 2);
    push(1, VIA, VIA, 1, 0, 2);
    push(0, NONE, VIA, 1, 0, D + 3);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL settings cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
  endtask

  task automatic test_nonhit();
    push(1, VIA, VIA, 3, 1, 3);
    push(0, NONE, VIA, 3, 1, 3);
    push(1, SND, VIA, 3, 1, 2);
    push(0, NONE, VIA, 3, 1, 14);
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL nonhit cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic b = logic'(k % 2);
      logic [5:0] e = 6'($urandom);
      logic [3:0] t = 4'($urandom_range(0, 3));
      logic g = 1'($urandom);
      int len = b ? $urandom_range(1, 6) : $urandom_range(1, 20);
      for (int j = 0; j < len; j++)
        q.push_back({b, ($urandom_range(0, 3) == 0) ? NONE : 6'(1 << $urandom_range(0, 5)), e, t, g});
    end
    foreach (q[i]) begin
      apply(q[i]); step(); vectors++;
      if ({Slow, SlowGate, SlowBusy} !== expOut()) begin
        miscompares++;
        $display("FAIL random cycle %0d: outputs=%b expected %b", cyc, {Slow, SlowGate, SlowBusy}, expOut());
      end
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_via_hold();
    test_scc();
    test_retrigger();
    test_settings();
    test_nonhit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
